// File: rtl/axi4_master_pkg.sv
// axi4_master_pkg: shared FSM states, AXI burst/size/response codes and response ordering helper
package axi4_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_beat_counter.sv
// axi4_beat_counter: counts data beats of one burst and flags the final beat
module axi4_beat_counter (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       load,
    input  logic       inc,
    input  logic [7:0] len,
    output logic       is_last
);

    logic [7:0] count;

    // cleared outside the data phases, advances once per data handshake
    always_ff @(posedge clk)
        if (!aresetn || load) count <= 8'd0;
        else if (inc) count <= count + 8'd1;

    assign is_last = count == len;

endmodule

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: single-command AXI4 INCR burst initiator; optional watchdog via AXI_MASTER_TIMEOUT_EN
module axi4_burst_master
    import axi4_master_pkg::*;
#(
    parameter int              ADDR_W = 6,
    parameter int              DATA_W = 32,
    parameter int              ID_W   = 2,
    parameter logic [ID_W-1:0] TXN_ID = 2'b11
) (
    input  logic                m00_axi_aclk,
    input  logic                m00_axi_aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_rnw,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    input  logic                rd_ready,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic [ADDR_W-1:0]   m00_axi_awaddr,
    output logic [7:0]          m00_axi_awlen,
    output logic [2:0]          m00_axi_awsize,
    output logic [1:0]          m00_axi_awburst,
    output logic [ID_W-1:0]     m00_axi_awid,
    output logic                m00_axi_awvalid,
    input  logic                m00_axi_awready,
    output logic [DATA_W-1:0]   m00_axi_wdata,
    output logic [DATA_W/8-1:0] m00_axi_wstrb,
    output logic                m00_axi_wlast,
    output logic                m00_axi_wvalid,
    input  logic                m00_axi_wready,
    input  logic [1:0]          m00_axi_bresp,
    input  logic [ID_W-1:0]     m00_axi_bid,
    input  logic                m00_axi_bvalid,
    output logic                m00_axi_bready,
    output logic [ADDR_W-1:0]   m00_axi_araddr,
    output logic [7:0]          m00_axi_arlen,
    output logic [2:0]          m00_axi_arsize,
    output logic [1:0]          m00_axi_arburst,
    output logic [ID_W-1:0]     m00_axi_arid,
    output logic                m00_axi_arvalid,
    input  logic                m00_axi_arready,
    input  logic [DATA_W-1:0]   m00_axi_rdata,
    input  logic [1:0]          m00_axi_rresp,
    input  logic                m00_axi_rlast,
    input  logic                m00_axi_rvalid,
    output logic                m00_axi_rready
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [1:0]        resp_q, resp_n;
    logic              is_last, cmd_bad, timeout;

    assign cmd_bad = int'(cmd_addr) + 4 * (int'(cmd_len) + 1) > (1 << ADDR_W);

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awlen   = len_q;
    assign m00_axi_awsize  = SIZE_4B;
    assign m00_axi_awburst = BURST_INCR;
    assign m00_axi_awid    = TXN_ID;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arlen   = len_q;
    assign m00_axi_arsize  = SIZE_4B;
    assign m00_axi_arburst = BURST_INCR;
    assign m00_axi_arid    = TXN_ID;
    assign done_resp       = resp_q;

    axi4_beat_counter u_beats (
        .clk    (m00_axi_aclk),
        .aresetn(m00_axi_aresetn),
        .load   (state != WR_DATA && state != RD_DATA),
        .inc    ((m00_axi_wvalid && m00_axi_wready) || (m00_axi_rvalid && m00_axi_rready)),
        .len    (len_q),
        .is_last(is_last)
    );

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [15:0] wd;
    logic        any_hs;

    assign any_hs = (m00_axi_awvalid && m00_axi_awready) || (m00_axi_wvalid && m00_axi_wready) ||
                    (m00_axi_bvalid && m00_axi_bready) || (m00_axi_arvalid && m00_axi_arready) ||
                    (m00_axi_rvalid && m00_axi_rready);
    assign timeout = state != IDLE && state != DONE && wd == 16'd0;

    // watchdog: rearmed by any bus progress or state change, counts down while a bus phase stalls
    always_ff @(posedge m00_axi_aclk)
        if (!m00_axi_aresetn || any_hs || state_n != state) wd <= 16'hFFFF;
        else if (state != IDLE && state != DONE) wd <= wd - 16'd1;
`else
    assign timeout = 1'b0;
`endif

    // state, latched command and worst-case response
    always_ff @(posedge m00_axi_aclk)
        if (!m00_axi_aresetn) begin
            state  <= IDLE;
            resp_q <= RESP_OKAY;
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_n;
            resp_q <= resp_n;
            if (cmd_valid && cmd_ready) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
            end
        end

    // next state, response folding and per-state channel outputs
    always_comb begin
        state_n         = state;
        resp_n          = resp_q;
        cmd_ready       = 1'b0;
        wr_ready        = 1'b0;
        rd_data         = '0;
        rd_valid        = 1'b0;
        rd_last         = 1'b0;
        done            = 1'b0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wdata   = '0;
        m00_axi_wstrb   = '0;
        m00_axi_wlast   = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = m00_axi_aresetn;
                if (cmd_valid && cmd_ready) begin
                    resp_n  = cmd_bad ? RESP_DECERR : RESP_OKAY;
                    state_n = cmd_bad ? DONE : cmd_rnw ? RD_ADDR : WR_ADDR;
                end
            end
            WR_ADDR: begin
                m00_axi_awvalid = !timeout;
                if (m00_axi_awvalid && m00_axi_awready) state_n = WR_DATA;
            end
            WR_DATA: begin
                m00_axi_wvalid = wr_valid && !timeout;
                wr_ready       = m00_axi_wready && !timeout;
                m00_axi_wdata  = wr_data;
                m00_axi_wstrb  = {(DATA_W/8){1'b1}};
                m00_axi_wlast  = is_last;
                if (m00_axi_wvalid && m00_axi_wready && is_last) state_n = WR_RESP;
            end
            WR_RESP: begin
                m00_axi_bready = !timeout;
                if (m00_axi_bready && m00_axi_bvalid) begin
                    resp_n  = resp_max(resp_q, m00_axi_bid == TXN_ID ? m00_axi_bresp : RESP_DECERR);
                    state_n = DONE;
                end
            end
            RD_ADDR: begin
                m00_axi_arvalid = !timeout;
                if (m00_axi_arvalid && m00_axi_arready) state_n = RD_DATA;
            end
            RD_DATA: begin
                rd_valid       = m00_axi_rvalid;
                rd_data        = m00_axi_rdata;
                rd_last        = m00_axi_rlast;
                m00_axi_rready = rd_ready && !timeout;
                if (m00_axi_rvalid && m00_axi_rready) begin
                    resp_n = resp_max(resp_max(resp_q, m00_axi_rresp),
                                      m00_axi_rlast != is_last ? RESP_DECERR : RESP_OKAY);
                    if (is_last) state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = DONE;
            resp_n  = RESP_DECERR;
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: directed and randomized commands against a spec-level slave/user model
module tb_axi4_burst_master;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready, done;
    logic [1:0]  done_resp;
    logic [5:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, awid, arid, bresp, bid, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int tests = 0;
    int fails = 0;
    logic [31:0] wdat [256];
    logic [31:0] rdat [256];
    logic [1:0]  rrsp [256];

    always #5 clk = ~clk;

    axi4_burst_master dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
        .m00_axi_awburst(awburst), .m00_axi_awid(awid), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bid(bid), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
        .m00_axi_arburst(arburst), .m00_axi_arid(arid), .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    endtask

    task automatic fill(input bit rnd_resp);
        for (int i = 0; i < 256; i++) begin
            wdat[i] = $urandom;
            rdat[i] = $urandom;
            rrsp[i] = (rnd_resp && $urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00;
        end
    endtask

    // one command: bench plays user and AXI slave, then checks against rules-derived expectations
    task automatic run(input logic rnw, input logic [5:0] addr, input logic [7:0] len, input int stall,
                       input logic [1:0] bresp_v, input logic [1:0] bid_v, input int early,
                       input bit no_last, input int rst_beat, input bit hang, input int bound);
        int cyc, done_cyc, w_cnt, r_cnt, aw_cnt, ar_cnt, order_err, data_err, last_err;
        bit aw_ok, ar_ok, b_done, bad;
        logic [1:0] exp_resp, got_resp;
        logic [20:0] aw_pl, ar_pl;
        done_cyc = -1; w_cnt = 0; r_cnt = 0; aw_cnt = 0; ar_cnt = 0;
        order_err = 0; data_err = 0; last_err = 0;
        aw_ok = 0; ar_ok = 0; b_done = 0; got_resp = 0; aw_pl = 0; ar_pl = 0;
        bad = int'(addr) + 4 * (int'(len) + 1) > 64;
        @(negedge clk);
        cmd_valid = 1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
        #1 chk("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        for (cyc = 1; cyc <= bound; cyc++) begin
            @(negedge clk);
            cmd_valid = 0;
            if (rst_beat >= 0 && aw_ok && w_cnt == rst_beat) begin
                aresetn = 0;
                @(posedge clk);
                #1;
                chk("rst_wvalid", wvalid, 0);
                chk("rst_awvalid", awvalid, 0);
                chk("rst_wlast_done", {wlast, done}, 0);
                chk("rst_resp", done_resp, 0);
                @(negedge clk);
                aresetn = 1;
                quiet();
                return;
            end
            awready  = !hang && ($urandom_range(99) >= stall);
            arready  = $urandom_range(99) >= stall;
            wready   = $urandom_range(99) >= stall;
            wr_valid = w_cnt <= len && $urandom_range(99) >= stall;
            wr_data  = wdat[w_cnt & 255];
            bvalid   = w_cnt == len + 1 && !b_done && $urandom_range(99) >= stall;
            bresp    = bresp_v;
            bid      = bid_v;
            rvalid   = ar_ok && r_cnt <= len && $urandom_range(99) >= stall;
            rdata    = rdat[r_cnt & 255];
            rresp    = rrsp[r_cnt & 255];
            rlast    = no_last ? 1'b0 : (early >= 0) ? (r_cnt == early) : (r_cnt == len);
            rd_ready = $urandom_range(99) >= stall;
            #1;
            if (done) begin
                done_cyc = cyc;
                got_resp = done_resp;
                break;
            end
            if (wvalid && !aw_ok) order_err++;
            if (awvalid && awready) begin
                aw_cnt++;
                aw_ok = 1;
                aw_pl = {awaddr, awlen, awsize, awburst, awid};
            end
            if (wvalid && wready) begin
                if (wdata !== wdat[w_cnt & 255] || wstrb !== 4'hF) data_err++;
                if (wlast !== (w_cnt == len)) last_err++;
                w_cnt++;
            end
            if (bvalid && bready) b_done = 1;
            if (arvalid && arready) begin
                ar_cnt++;
                ar_ok = 1;
                ar_pl = {araddr, arlen, arsize, arburst, arid};
            end
            if (rvalid && rready) begin
                if (!rd_valid || rd_data !== rdat[r_cnt & 255] || rd_last !== rlast) data_err++;
                r_cnt++;
            end
        end
        if (bad || hang) exp_resp = 2'b11;
        else if (rnw) begin
            exp_resp = 2'b00;
            for (int i = 0; i <= int'(len); i++) exp_resp = worst(exp_resp, rrsp[i]);
            if (no_last || (early >= 0 && early != int'(len))) exp_resp = 2'b11;
        end else exp_resp = worst(bresp_v, bid_v != 2'b11 ? 2'b11 : 2'b00);
        chk("done_seen", done_cyc > 0, 1);
        chk("done_resp", got_resp, exp_resp);
        if (hang) begin
            chk("hang_no_aw", aw_cnt, 0);
            chk("hang_wait", done_cyc >= 65535, 1);
        end else if (bad) begin
            chk("bad_no_bus", aw_cnt + ar_cnt, 0);
            chk("bad_latency", done_cyc, 1);
        end else if (!rnw) begin
            chk("aw_count", aw_cnt, 1);
            chk("aw_payload", aw_pl, {addr, len, 3'b010, 2'b01, 2'b11});
            chk("w_beats", w_cnt, int'(len) + 1);
            chk("w_data_err", data_err, 0);
            chk("w_last_err", last_err, 0);
            chk("w_before_aw", order_err, 0);
            if (stall == 0) chk("wr_latency", done_cyc, 4 + int'(len));
        end else begin
            chk("ar_count", ar_cnt, 1);
            chk("ar_payload", ar_pl, {addr, len, 3'b010, 2'b01, 2'b11});
            chk("r_beats", r_cnt, int'(len) + 1);
            chk("r_data_err", data_err, 0);
            if (stall == 0) chk("rd_latency", done_cyc, 3 + int'(len));
        end
        @(negedge clk);
        quiet();
        #1;
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", cmd_ready, 1);
        if (done_cyc < 0) begin
            aresetn = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            aresetn = 1;
        end
    endtask

    initial begin
        aresetn = 0;
        quiet();
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, done}, 0);
        @(negedge clk);
        aresetn = 1;
        @(negedge clk);
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_resp", done_resp, 0);
        chk("idle_addr", {awaddr, awlen}, 0);

        wdat[0] = 32'hFFFFFFFF;
        run(0, 6'h04, 8'd0, 0, 2'b00, 2'b11, -1, 0, -1, 0, 200);

        wdat[0] = 32'hABABABAB; wdat[1] = 32'hCDCDCDCD; wdat[2] = 32'hEFEFEFEF;
        run(0, 6'h08, 8'd2, 30, 2'b00, 2'b11, -1, 0, -1, 0, 500);

        rdat[0] = 32'hFFFFFFFF;
        run(1, 6'h04, 8'd0, 0, 2'b00, 2'b11, -1, 0, -1, 0, 200);

        run(0, 6'h10, 8'd1, 0, 2'b10, 2'b11, -1, 0, -1, 0, 200);
        run(0, 6'h10, 8'd0, 0, 2'b00, 2'b01, -1, 0, -1, 0, 200);
        run(1, 6'h00, 8'd3, 0, 2'b00, 2'b11, 1, 0, -1, 0, 200);
        run(1, 6'h20, 8'd2, 20, 2'b00, 2'b11, -1, 1, -1, 0, 500);
        run(1, 6'h3C, 8'd1, 0, 2'b00, 2'b11, -1, 0, -1, 0, 200);
        run(0, 6'h34, 8'd3, 0, 2'b00, 2'b11, -1, 0, -1, 0, 200);
        run(0, 6'h30, 8'd3, 0, 2'b00, 2'b11, -1, 0, -1, 0, 200);

        fill(0);
        run(0, 6'h00, 8'd3, 0, 2'b00, 2'b11, -1, 0, 2, 0, 200);
        run(0, 6'h04, 8'd1, 0, 2'b00, 2'b11, -1, 0, -1, 0, 200);

        for (int n = 0; n < 10; n++) begin
            logic [7:0] l;
            logic [5:0] a;
            fill(1);
            l = 8'($urandom_range(7));
            a = 6'($urandom_range(15) << 2);
            run(1'($urandom_range(1)), a, l, $urandom_range(40), 2'($urandom_range(3)),
                ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b11, -1, 0, -1, 0, 1000);
        end

`ifdef AXI_MASTER_TIMEOUT_EN
        run(0, 6'h10, 8'd0, 0, 2'b00, 2'b11, -1, 0, -1, 1, 70000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
AXI4 (full) initiator engine that drives the AES IP's `s00_axi` slave port. It is the other end of the interface that `myip_axi_v1_0` responds on. It accepts one command at a time (read or write, start address, beat count) on a simple valid/ready command port, runs one INCR burst of 32-bit beats, streams data to and from user-side valid/ready ports, and reports a completion status. Used in the SoC wrapper and as the bus-functional driver in self-checking benches.

Parameters:
ADDR_W, 6, address width; matches the slave's register map.
DATA_W, 32, data width; fixed 32, WSTRB width DATA_W/8.
ID_W, 2, AWID/ARID width.
TXN_ID, 2'b11, constant ID driven on AWID/ARID.

Ports:
m00_axi_aclk  in  1  clock
m00_axi_aresetn  in  1  reset; synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_rnw  in  1  1 = read, 0 = write
cmd_addr  in  ADDR_W  start byte address; bits [1:0] must be 0
cmd_len  in  8  beats-1 (AXI LEN encoding)
wr_data  in  DATA_W  user write beat
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat consumed
rd_data  out  DATA_W  read beat
rd_valid  out  1  read beat valid
rd_last  out  1  final read beat
rd_ready  in  1  user accepts read beat
done  out  1  one-cycle pulse at end of command
done_resp  out  2  worst response seen (OKAY 00 < EXOKAY 01 < SLVERR 10 < DECERR 11); 2'b11 also on protocol error
m00_axi_awaddr/awlen/awsize/awburst/awid/awvalid  out  ADDR_W/8/3/2/ID_W/1  AW channel
m00_axi_awready  in  1
m00_axi_wdata/wstrb/wlast/wvalid  out  DATA_W/4/1/1  W channel
m00_axi_wready  in  1
m00_axi_bresp  in  2 ; m00_axi_bid  in  ID_W ; m00_axi_bvalid  in  1 ; m00_axi_bready  out  1
m00_axi_araddr/arlen/arsize/arburst/arid/arvalid  out  ADDR_W/8/3/2/ID_W/1  AR channel
m00_axi_arready  in  1
m00_axi_rdata  in  DATA_W ; m00_axi_rresp  in  2 ; m00_axi_rlast  in  1 ; m00_axi_rvalid  in  1 ; m00_axi_rready  out  1

Behaviour:
- Reset (synchronous): all valid/ready/last/done outputs drop to 0 at the first edge with aresetn low. Address, data and len outputs go to 0; done_resp = 0. FSM goes to IDLE. This applies mid-burst too, and the resulting abandoned AXI transaction is accepted.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: cmd_ready = 1.
  - On cmd_valid&&cmd_ready: latch addr, len, rnw; go to WR_ADDR or RD_ADDR.
  - If cmd_addr + 4*(cmd_len+1) > 2^ADDR_W: go straight to DONE with done_resp = 2'b11 and issue no bus traffic.
- WR_ADDR / RD_ADDR:
  - awvalid/arvalid = 1 starting the cycle after acceptance, held with stable payload until ready.
  - Payload: size = 3'b010, burst = 2'b01 (INCR), id = TXN_ID.
  - On handshake go to WR_DATA / RD_DATA.
- Writes are strictly sequential: no W beat is issued before the AW handshake.
- WR_DATA:
  - wvalid = wr_valid; wr_ready = m00_axi_wready (combinational pass-through); wdata = wr_data; wstrb = 4'hF.
  - Beat counter increments on each W handshake; wlast = (count == len).
  - After the last handshake go to WR_RESP.
- WR_RESP: bready = 1; on bvalid, record bresp.
  - If bid != TXN_ID, record 2'b11.
  - Go to DONE.
- RD_DATA:
  - rd_valid = rvalid; rready = rd_ready; rd_data = rdata; rd_last = rlast.
  - Each handshake folds rresp into the worst-case register.
  - Protocol error (done_resp = 2'b11):
    - rlast on a beat other than count == len;
    - no rlast on count == len.
  - A missing rlast ends the command at beat len+1 beats regardless.
- DONE: done = 1 for exactly one cycle; back to IDLE next cycle (cmd_ready returns to 1 then).
- Latency, zero-wait slave:
  - Write command accept to done = 4 + len cycles.
  - Read command accept to done = 3 + len cycles.
- Beat counter is 8 bits. len = 255 gives 256 beats with no wrap fault.

Optional Feature:
AXI_MASTER_TIMEOUT_EN.
- Defined: a 16-bit watchdog reloads to 0xFFFF on every handshake and on entry to any non-IDLE state, and decrements otherwise. On reaching 0:
  - drop all AXI valid/ready outputs;
  - done_resp = 2'b11;
  - go to DONE.
- Undefined: no watchdog, and the block waits indefinitely.

Decomposition:
- Package `axi4_master_pkg`:
  - state enum;
  - BURST_INCR = 2'b01, SIZE_4B = 3'b010;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - a resp_max function.
- One sub-module is natural: `axi4_beat_counter` (load, increment on handshake, is_last compare against len), shared by the write and read paths.

Test Plan:
1. Single write: cmd addr 0x04, len 0, wr_data 0xFFFFFFFF, zero-wait slave -> awaddr 0x04, awlen 0, wlast on the sole beat, done after 4 cycles with resp 00.
2. Burst write: addr 0x08, len 2, data 0xABABABAB/0xCDCDCDCD/0xEFEFEFEF, random wready stalls -> 3 beats in order, wlast only on 0xEFEFEFEF, done resp 00.
3. Read: addr 0x04, len 0, slave returns 0xFFFFFFFF with rlast -> rd_data 0xFFFFFFFF, rd_last 1, done resp 00.
4. Error paths:
   - bresp 2'b10 -> done_resp 2'b10.
   - 4-beat read with early rlast on beat 1 -> done_resp 2'b11.
   - cmd addr 0x3C, len 1 -> no AW/AR valid, done_resp 2'b11.
5. Reset mid-burst: aresetn low during beat 2 of a len-3 write -> wvalid/awvalid 0 at the next edge; a fresh command afterwards completes normally.
6. With AXI_MASTER_TIMEOUT_EN: the slave never asserts awready -> done pulse with resp 2'b11 after 65535 stalled cycles.
